// File: rtl/syn_lb_fabric_pkg.sv
// Shared types and constants for the local-bus fabric.
package syn_lb_fabric_pkg;

    // Transaction FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Why the last response was flagged as an error (kept for debug visibility)
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_DECODE  = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ILLEGAL = 2'd3
    } err_cause_e;

    // Read data returned on any error response
    localparam logic [31:0] ERR_RD_DATA_DEF = 32'hDEADBEEF;

    // Width of the WAIT-state timeout counter
    localparam int CNT_W = 16;

endpackage

// File: rtl/syn_lb_addr_dec.sv
// Slave-select decode: extracts the select field from the top address bits,
// range-checks it against the number of attached slaves and builds a one-hot.
module syn_lb_addr_dec #(
    parameter  int NUM_SLAVES = 4,
    parameter  int LB_ADDR_W  = 12,
    localparam int SEL_W      = $clog2(NUM_SLAVES),
    localparam int LOC_W      = LB_ADDR_W - SEL_W
) (
    input  logic [LB_ADDR_W-1:0]  addr_i,
    output logic                  in_range_o,
    output logic [NUM_SLAVES-1:0] onehot_o,
    output logic [LOC_W-1:0]      loc_addr_o
);
    import syn_lb_fabric_pkg::*;

    localparam logic [SEL_W:0] NUM_S = (SEL_W + 1)'(NUM_SLAVES);

    logic [SEL_W-1:0] sel;

    assign sel        = addr_i[LB_ADDR_W-1 -: SEL_W];
    assign loc_addr_o = addr_i[LOC_W-1:0];
    assign in_range_o = ({1'b0, sel} < NUM_S);

    // One-hot of the selected slave; all zero when the select is out of range
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (in_range_o && (sel == SEL_W'(i))) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/syn_lb_fabric.sv
// Local-bus interconnect: one master, NUM_SLAVES slaves. Registers each request,
// strobes a single slave, waits for its ack (bounded by a timeout) and returns
// one registered response carrying an error qualifier.
module syn_lb_fabric
    import syn_lb_fabric_pkg::*;
#(
    parameter  int                   NUM_SLAVES     = 4,
    parameter  int                   LB_ADDR_W      = 12,
    parameter  int                   LB_DATA_W      = 32,
    parameter  int                   TIMEOUT_CYCLES = 64,
    parameter  logic [LB_DATA_W-1:0] ERR_RD_DATA    = LB_DATA_W'(ERR_RD_DATA_DEF),
    localparam int                   SEL_W          = $clog2(NUM_SLAVES),
    localparam int                   LOC_W          = LB_ADDR_W - SEL_W
) (
    input  logic                             clk_ir,
    input  logic                             rst_il,
    input  logic                             lbm_wr_en,
    input  logic                             lbm_rd_en,
    input  logic [LB_ADDR_W-1:0]             lbm_addr,
    input  logic [LB_DATA_W-1:0]             lbm_wr_data,
    output logic                             lbm_busy,
    output logic                             lbm_wr_valid,
    output logic                             lbm_rd_valid,
    output logic [LB_DATA_W-1:0]             lbm_rd_data,
    output logic                             lbm_err,
    output logic                             lbm_drop,
    output logic [NUM_SLAVES-1:0]            slv_wr_en,
    output logic [NUM_SLAVES-1:0]            slv_rd_en,
    output logic [LOC_W-1:0]                 slv_addr,
    output logic [LB_DATA_W-1:0]             slv_wr_data,
    input  logic [NUM_SLAVES-1:0]            slv_wr_valid,
    input  logic [NUM_SLAVES-1:0]            slv_rd_valid,
    input  logic [NUM_SLAVES*LB_DATA_W-1:0]  slv_rd_data
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                  state_q,       state_d;
    err_cause_e              cause_q,       cause_d;
    logic [CNT_W-1:0]        cnt_q,         cnt_d;
    logic                    dir_rd_q,      dir_rd_d;
    logic [NUM_SLAVES-1:0]   oh_q,          oh_d;
    logic [NUM_SLAVES-1:0]   slv_wr_en_q,   slv_wr_en_d;
    logic [NUM_SLAVES-1:0]   slv_rd_en_q,   slv_rd_en_d;
    logic [LOC_W-1:0]        slv_addr_q,    slv_addr_d;
    logic [LB_DATA_W-1:0]    slv_wr_data_q, slv_wr_data_d;
    logic                    wr_valid_q,    wr_valid_d;
    logic                    rd_valid_q,    rd_valid_d;
    logic [LB_DATA_W-1:0]    rd_data_q,     rd_data_d;
    logic                    drop_q,        drop_d;

    logic                    dec_in_range;
    logic [NUM_SLAVES-1:0]   dec_onehot;
    logic [LOC_W-1:0]        dec_loc_addr;
    logic                    ack;
    logic [LB_DATA_W-1:0]    rd_sel;

    syn_lb_addr_dec #(
        .NUM_SLAVES (NUM_SLAVES),
        .LB_ADDR_W  (LB_ADDR_W)
    ) u_addr_dec (
        .addr_i     (lbm_addr),
        .in_range_o (dec_in_range),
        .onehot_o   (dec_onehot),
        .loc_addr_o (dec_loc_addr)
    );

    // Ack and read data of the latched slave only; foreign or wrong-direction acks are masked
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (oh_q[i]) begin
                rd_sel = rd_sel | slv_rd_data[i*LB_DATA_W +: LB_DATA_W];
            end
        end
        ack = dir_rd_q ? |(slv_rd_valid & oh_q) : |(slv_wr_valid & oh_q);
    end

    // Transaction FSM: next state, strobes and response contents
    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        cnt_d         = cnt_q;
        dir_rd_d      = dir_rd_q;
        oh_d          = oh_q;
        slv_wr_en_d   = '0;
        slv_rd_en_d   = '0;
        slv_addr_d    = slv_addr_q;
        slv_wr_data_d = slv_wr_data_q;
        wr_valid_d    = 1'b0;
        rd_valid_d    = 1'b0;
        rd_data_d     = rd_data_q;
        drop_d        = (state_q != IDLE) && (lbm_wr_en || lbm_rd_en);

        case (state_q)
            IDLE: begin
                if (lbm_wr_en && lbm_rd_en) begin
                    // Ambiguous direction: answer both sides with an error, touch no slave
                    state_d    = RESP;
                    cause_d    = ERR_ILLEGAL;
                    wr_valid_d = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_data_d  = ERR_RD_DATA;
                end else if (lbm_wr_en || lbm_rd_en) begin
                    dir_rd_d      = lbm_rd_en;
                    oh_d          = dec_onehot;
                    slv_addr_d    = dec_loc_addr;
                    slv_wr_data_d = lbm_wr_data;
                    if (!dec_in_range) begin
                        state_d    = RESP;
                        cause_d    = ERR_DECODE;
                        wr_valid_d = lbm_wr_en;
                        rd_valid_d = lbm_rd_en;
                        if (lbm_rd_en) begin
                            rd_data_d = ERR_RD_DATA;
                        end
                    end else begin
                        slv_wr_en_d = lbm_wr_en ? dec_onehot : '0;
                        slv_rd_en_d = lbm_rd_en ? dec_onehot : '0;
                        cnt_d       = '0;
                        state_d     = WAIT;
                    end
                end
            end

            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Ack is checked first so it wins over a coincident timeout
                if (ack) begin
                    state_d    = RESP;
                    cause_d    = ERR_NONE;
                    wr_valid_d = !dir_rd_q;
                    rd_valid_d = dir_rd_q;
                    if (dir_rd_q) begin
                        rd_data_d = rd_sel;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d    = RESP;
                    cause_d    = ERR_TIMEOUT;
                    wr_valid_d = !dir_rd_q;
                    rd_valid_d = dir_rd_q;
                    if (dir_rd_q) begin
                        rd_data_d = ERR_RD_DATA;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction silently
    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            state_q       <= IDLE;
            cause_q       <= ERR_NONE;
            cnt_q         <= '0;
            dir_rd_q      <= 1'b0;
            oh_q          <= '0;
            slv_wr_en_q   <= '0;
            slv_rd_en_q   <= '0;
            slv_addr_q    <= '0;
            slv_wr_data_q <= '0;
            wr_valid_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            cnt_q         <= cnt_d;
            dir_rd_q      <= dir_rd_d;
            oh_q          <= oh_d;
            slv_wr_en_q   <= slv_wr_en_d;
            slv_rd_en_q   <= slv_rd_en_d;
            slv_addr_q    <= slv_addr_d;
            slv_wr_data_q <= slv_wr_data_d;
            wr_valid_q    <= wr_valid_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            drop_q        <= drop_d;
        end
    end

    assign lbm_busy     = (state_q != IDLE);
    assign lbm_wr_valid = wr_valid_q;
    assign lbm_rd_valid = rd_valid_q;
    assign lbm_rd_data  = rd_data_q;
    assign lbm_err      = (cause_q != ERR_NONE);
    assign lbm_drop     = drop_q;
    assign slv_wr_en    = slv_wr_en_q;
    assign slv_rd_en    = slv_rd_en_q;
    assign slv_addr     = slv_addr_q;
    assign slv_wr_data  = slv_wr_data_q;

endmodule

// File: tb/tb_syn_lb_fabric.sv
// Testbench for syn_lb_fabric: a 4-slave instance checked through a response
// scoreboard, plus a 3-slave instance for the decode-range boundary.
module tb_syn_lb_fabric;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected responses
    always @(posedge clk) cyc <= cyc + 1;

    // 4-slave instance signals
    logic         m_wr_en, m_rd_en;
    logic [11:0]  m_addr;
    logic [31:0]  m_wdata;
    logic         m_busy, m_wv, m_rv, m_err, m_drop;
    logic [31:0]  m_rdata;
    logic [3:0]   s_wr_en, s_rd_en, s_wv, s_rv;
    logic [9:0]   s_addr;
    logic [31:0]  s_wdata;
    logic [127:0] s_rdata;

    // 3-slave instance signals
    logic         d3_wr_en, d3_rd_en;
    logic [11:0]  d3_addr;
    logic [31:0]  d3_wdata;
    logic         d3_busy, d3_wv, d3_rv, d3_err, d3_drop;
    logic [31:0]  d3_rdata;
    logic [2:0]   d3_s_wr_en, d3_s_rd_en, d3_s_wv, d3_s_rv;
    logic [9:0]   d3_s_addr;
    logic [31:0]  d3_s_wdata;
    logic [95:0]  d3_s_rdata;

    syn_lb_fabric #(.NUM_SLAVES(4), .LB_ADDR_W(12), .LB_DATA_W(32), .TIMEOUT_CYCLES(64)) u_dut4 (
        .clk_ir(clk), .rst_il(rst),
        .lbm_wr_en(m_wr_en), .lbm_rd_en(m_rd_en), .lbm_addr(m_addr), .lbm_wr_data(m_wdata),
        .lbm_busy(m_busy), .lbm_wr_valid(m_wv), .lbm_rd_valid(m_rv), .lbm_rd_data(m_rdata),
        .lbm_err(m_err), .lbm_drop(m_drop),
        .slv_wr_en(s_wr_en), .slv_rd_en(s_rd_en), .slv_addr(s_addr), .slv_wr_data(s_wdata),
        .slv_wr_valid(s_wv), .slv_rd_valid(s_rv), .slv_rd_data(s_rdata)
    );

    syn_lb_fabric #(.NUM_SLAVES(3), .LB_ADDR_W(12), .LB_DATA_W(32), .TIMEOUT_CYCLES(64)) u_dut3 (
        .clk_ir(clk), .rst_il(rst),
        .lbm_wr_en(d3_wr_en), .lbm_rd_en(d3_rd_en), .lbm_addr(d3_addr), .lbm_wr_data(d3_wdata),
        .lbm_busy(d3_busy), .lbm_wr_valid(d3_wv), .lbm_rd_valid(d3_rv), .lbm_rd_data(d3_rdata),
        .lbm_err(d3_err), .lbm_drop(d3_drop),
        .slv_wr_en(d3_s_wr_en), .slv_rd_en(d3_s_rd_en), .slv_addr(d3_s_addr), .slv_wr_data(d3_s_wdata),
        .slv_wr_valid(d3_s_wv), .slv_rd_valid(d3_s_rv), .slv_rd_data(d3_s_rdata)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic        wv;
        logic        rv;
        logic        err;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic expect_resp(input logic wv, input logic rv, input logic err,
                               input logic [31:0] data, input int at);
        exp_t e;
        e.wv = wv; e.rv = rv; e.err = err; e.data = data; e.at = at;
        sb.push_back(e);
    endtask

    // Response monitor for the 4-slave instance
    always @(negedge clk) begin
        if (m_wv || m_rv) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {62'd0, m_wv, m_rv}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_wr_valid", m_wv, mon_e.wv);
                chk("resp_rd_valid", m_rv, mon_e.rv);
                chk("resp_err", m_err, mon_e.err);
                chk("resp_cycle", cyc, mon_e.at);
                if (mon_e.rv) chk("resp_rd_data", m_rdata, mon_e.data);
            end
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int t0, t1;

    initial begin
        m_wr_en = 0; m_rd_en = 0; m_addr = '0; m_wdata = '0; s_wv = '0; s_rv = '0; s_rdata = '0;
        d3_wr_en = 0; d3_rd_en = 0; d3_addr = '0; d3_wdata = '0; d3_s_wv = '0; d3_s_rv = '0; d3_s_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_ctrl", {51'd0, m_busy, m_wv, m_rv, m_err, m_drop, s_wr_en, s_rd_en}, 64'd0);
        chk("rst_rd_data", m_rdata, 64'd0);
        chk("rst_slv_addr", s_addr, 64'd0);
        chk("rst_slv_wdata", s_wdata, 64'd0);
        chk("rst_d3_busy", d3_busy, 64'd0);
        @(negedge clk);

        // Write slave 2, ack three cycles after the strobe
        t0 = cyc;
        m_wr_en = 1; m_addr = 12'h805; m_wdata = 32'h1234;
        expect_resp(1, 0, 0, 32'h0, t0 + 5);
        @(negedge clk);
        m_wr_en = 0;
        chk("wr_strobe", s_wr_en, 64'h4);
        chk("wr_no_rd_strobe", s_rd_en, 64'h0);
        chk("wr_slv_addr", s_addr, 64'h005);
        chk("wr_slv_data", s_wdata, 64'h1234);
        chk("wr_busy", m_busy, 64'd1);
        @(negedge clk);
        chk("wr_strobe_one_cycle", s_wr_en, 64'h0);
        wait_to(t0 + 4);
        s_wv = 4'b0100;
        @(negedge clk);
        s_wv = '0;
        wait_to(t0 + 7);
        chk("wr_idle_after", m_busy, 64'd0);

        // Read slave 3, ack in the strobe cycle
        t0 = cyc;
        m_rd_en = 1; m_addr = 12'hC10;
        expect_resp(0, 1, 0, 32'hCAFE0001, t0 + 2);
        @(negedge clk);
        m_rd_en = 0;
        chk("rd_strobe", s_rd_en, 64'h8);
        chk("rd_slv_addr", s_addr, 64'h010);
        s_rv = 4'b1000; s_rdata[96 +: 32] = 32'hCAFE0001;
        @(negedge clk);
        s_rv = '0;
        wait_to(t0 + 4);
        chk("rd_data_hold", m_rdata, 64'hCAFE0001);

        // Read slave 1 with no ack: timeout, then a late ack that must be ignored
        t0 = cyc;
        m_rd_en = 1; m_addr = 12'h420;
        expect_resp(0, 1, 1, 32'hDEADBEEF, t0 + 65);
        @(negedge clk);
        m_rd_en = 0;
        chk("to_strobe", s_rd_en, 64'h2);
        wait_to(t0 + 64);
        chk("to_still_busy", m_busy, 64'd1);
        wait_to(t0 + 70);
        s_rv = 4'b0010; s_rdata[32 +: 32] = 32'h11111111;
        @(negedge clk);
        s_rv = '0;
        @(negedge clk);
        t1 = cyc;
        m_wr_en = 1; m_addr = 12'h010; m_wdata = 32'hA5;
        expect_resp(1, 0, 0, 32'h0, t1 + 2);
        @(negedge clk);
        m_wr_en = 0;
        chk("post_to_strobe", s_wr_en, 64'h1);
        s_wv = 4'b0001;
        @(negedge clk);
        s_wv = '0;
        @(negedge clk);

        // Foreign ack, wrong-direction ack and a dropped request while waiting on slave 0
        t0 = cyc;
        m_rd_en = 1; m_addr = 12'h033;
        expect_resp(0, 1, 0, 32'h55, t0 + 5);
        @(negedge clk);
        m_rd_en = 0;
        s_rv = 4'b0100; s_rdata[64 +: 32] = 32'h22222222;
        @(negedge clk);
        s_rv = '0;
        m_wr_en = 1; m_addr = 12'h100;
        @(negedge clk);
        m_wr_en = 0;
        chk("drop_pulse", m_drop, 64'd1);
        chk("drop_no_strobe", s_wr_en, 64'h0);
        s_wv = 4'b0001;
        @(negedge clk);
        s_wv = '0;
        chk("drop_one_cycle", m_drop, 64'd0);
        s_rv = 4'b0001; s_rdata[0 +: 32] = 32'h55;
        @(negedge clk);
        s_rv = '0;
        @(negedge clk);

        // Reset while waiting on slave 2: everything clears, no response
        t0 = cyc;
        m_rd_en = 1; m_addr = 12'h800;
        @(negedge clk);
        m_rd_en = 0;
        chk("rstw_strobe", s_rd_en, 64'h4);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rstw_ctrl", {51'd0, m_busy, m_wv, m_rv, m_err, m_drop, s_wr_en, s_rd_en}, 64'd0);
        chk("rstw_rd_data", m_rdata, 64'd0);
        chk("rstw_slv_addr", s_addr, 64'd0);
        s_rv = 4'b0100;
        @(negedge clk);
        s_rv = '0;
        wait_to(t0 + 8);
        chk("rstw_idle", m_busy, 64'd0);

        // Write and read both asserted: both valids with error at cycle 1
        t0 = cyc;
        m_wr_en = 1; m_rd_en = 1; m_addr = 12'h805;
        expect_resp(1, 1, 1, 32'hDEADBEEF, t0 + 1);
        @(negedge clk);
        m_wr_en = 0; m_rd_en = 0;
        chk("illegal_no_strobe", {s_wr_en, s_rd_en}, 64'h0);
        repeat (2) @(negedge clk);

        // Three-slave instance: select 3 is out of range
        t0 = cyc;
        d3_rd_en = 1; d3_addr = 12'hC00;
        @(negedge clk);
        d3_rd_en = 0;
        chk("dec_rd_valid", d3_rv, 64'd1);
        chk("dec_wr_valid", d3_wv, 64'd0);
        chk("dec_err", d3_err, 64'd1);
        chk("dec_rd_data", d3_rdata, 64'hDEADBEEF);
        chk("dec_no_strobe", d3_s_rd_en, 64'h0);
        @(negedge clk);
        chk("dec_one_cycle", d3_rv, 64'd0);
        @(negedge clk);
        d3_rd_en = 1; d3_addr = 12'h8AB;
        @(negedge clk);
        d3_rd_en = 0;
        chk("d3_strobe", d3_s_rd_en, 64'h4);
        chk("d3_slv_addr", d3_s_addr, 64'h0AB);
        d3_s_rv = 3'b100; d3_s_rdata[64 +: 32] = 32'h77;
        @(negedge clk);
        d3_s_rv = '0;
        chk("d3_rd_valid", d3_rv, 64'd1);
        chk("d3_rd_data", d3_rdata, 64'h77);
        chk("d3_err", d3_err, 64'd0);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/syn_lb_fabric.md
# syn_lb_fabric

Parametrised local-bus interconnect between one LB master and NUM_SLAVES slaves. It decodes slave select from the upper address bits, registers the request and strobes exactly one slave. It then waits for that slave's write/read acknowledge with a timeout, and returns a single registered response with an error flag. It replaces the fixed, purely combinational per-block LB fabrics in the audio and video cortex subsystems.

## Interface
- NUM_SLAVES, 4: attached slaves, 2..16
- LB_ADDR_W, 12: master address width; slave select = top SEL_W bits, SEL_W = $clog2(NUM_SLAVES)
- LB_DATA_W, 32: data width; narrower slaves zero-extend their own read data
- TIMEOUT_CYCLES, 64: cycles in WAIT before error response, 1..2^16-1
- ERR_RD_DATA, 32'hDEADBEEF: read data returned on any error
- clk_ir  in  1  clock
- rst_il  in  1  reset, synchronous, active-high
- lbm_wr_en  in  1  write request pulse
- lbm_rd_en  in  1  read request pulse
- lbm_addr  in  LB_ADDR_W  request address
- lbm_wr_data  in  LB_DATA_W  write data
- lbm_busy  out  1  transaction in flight
- lbm_wr_valid  out  1  write complete pulse
- lbm_rd_valid  out  1  read data valid pulse
- lbm_rd_data  out  LB_DATA_W  read data, valid with lbm_rd_valid
- lbm_err  out  1  error qualifier, valid with either valid pulse
- lbm_drop  out  1  pulse: request arrived while busy and was discarded
- slv_wr_en  out  NUM_SLAVES  one-hot write strobe
- slv_rd_en  out  NUM_SLAVES  one-hot read strobe
- slv_addr  out  LB_ADDR_W-SEL_W  slave-local address (registered)
- slv_wr_data  out  LB_DATA_W  registered write data
- slv_wr_valid  in  NUM_SLAVES  per-slave write ack
- slv_rd_valid  in  NUM_SLAVES  per-slave read ack
- slv_rd_data  in  NUM_SLAVES*LB_DATA_W  packed read data, slave i at [i*LB_DATA_W +: LB_DATA_W]

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: a request is lbm_wr_en XOR lbm_rd_en.
  - Both high is illegal: no strobe; go to RESP with lbm_err=1. A read gets ERR_RD_DATA; if both were high, lbm_wr_valid and lbm_rd_valid both pulse.
- Valid request: latch addr, data, direction and sel = lbm_addr[LB_ADDR_W-1 -: SEL_W].
  - If sel >= NUM_SLAVES (decode error): go to RESP with err=1, no strobe.
  - Otherwise: assert slv_wr_en[sel] or slv_rd_en[sel] for exactly the next cycle, clear the timeout counter, go to WAIT.
- WAIT: the counter increments each cycle. Only the selected slave's ack of the matching direction is honoured; all other acks are ignored.
  - On ack: capture slv_rd_data slice (reads), go to RESP, err=0.
  - Counter == TIMEOUT_CYCLES-1 with no ack: go to RESP with err=1, rd_data=ERR_RD_DATA.
  - Ack and timeout in the same cycle: the ack wins.
- RESP: exactly one of lbm_wr_valid/lbm_rd_valid (or both on illegal request) is high for one cycle, with lbm_err and lbm_rd_data. Then go to IDLE.
- lbm_busy = (state != IDLE). Requests while busy are dropped with a lbm_drop pulse the following cycle. No queueing.
- Acks arriving in IDLE or RESP, including late acks after a timeout, are ignored.
- lbm_rd_data holds its last value outside valid pulses.
- Reset (any state): state=IDLE and counter=0. All outputs reset to 0, including lbm_rd_data, strobes, slv_addr and slv_wr_data. Any in-flight transaction is abandoned with no response.

## Timing
- Request sampled at cycle 0; slave strobe at cycle 1.
- Slave ack at cycle k >= 1 (an ack in the strobe cycle is legal) gives the master valid at cycle k+1. Minimum latency is 2 cycles.
- Timeout: strobe at cycle 1, err response at cycle TIMEOUT_CYCLES+1.
- Decode/illegal error: response at cycle 1.
- Next request is accepted earliest in the cycle after the valid pulse.
- All outputs are registered; no combinational path from slave inputs to master outputs.

## Structure
- Package syn_lb_fabric_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - error-cause enum (NONE, DECODE, TIMEOUT, ILLEGAL), carried internally for debug
  - default ERR_RD_DATA constant
- Sub-module syn_lb_addr_dec: combinational sel extraction, range check and one-hot generation. Parameters NUM_SLAVES and LB_ADDR_W.
- Top holds the FSM, timeout counter, request/response registers and read mux.

## Test plan
- NUM_SLAVES=4, LB_ADDR_W=12: write addr 12'h805 data 0x1234 → slv_wr_en=4'b0100 for one cycle, slv_addr=10'h005. Ack 3 cycles later → lbm_wr_valid one cycle later, err=0.
- Read slave 3, addr 12'hC10; slave acks in the strobe cycle with 0xCAFE0001 → lbm_rd_valid at cycle 2 with that data, err=0.
- NUM_SLAVES=3, read addr 12'hC00 → no strobe, lbm_rd_valid at cycle 1, err=1, data 0xDEADBEEF.
- Read slave 1, no ack, TIMEOUT_CYCLES=64 → err response at cycle 65. A late ack at cycle 70 is ignored, and the next request proceeds normally.
- Slave 2 acks while slave 0 is selected, and a second request arrives in WAIT. The foreign ack is ignored, lbm_drop pulses, and slave 0's ack completes the transaction.
- Assert rst_il in WAIT → all outputs 0 the next cycle, busy=0, no valid pulse. Simultaneous wr_en and rd_en → both valids with err=1 at cycle 1.
